// File: rtl/int_to_float_pipe_pkg.sv
// Purpose: shared FP32 field constants and pipeline stage payload types for the int<->float converters.
// Latency: none (types and constants only).
// Backpressure: none (no logic).
package int_to_float_pipe_pkg;

  localparam int EXP_W              = 8;
  localparam int FRAC_W             = 23;
  localparam int EXP_BIAS           = 127;
  // Exponent of a value whose leading one sits at bit 31 of the magnitude.
  localparam int INT_TO_FP_EXP_BASE = EXP_BIAS + 31;

  // Canonical zero: always +0, never -0.
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // S1 payload: sign and unsigned magnitude of the operand.
  typedef struct packed {
    logic        sign;
    logic        zero;
    logic [31:0] mag;
  } s1_t;

  // S2 payload: normalized magnitude with the implicit leading one dropped.
  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [30:0]      m;
    logic [EXP_W-1:0] e;
  } s2_t;

  // S3 payload: packed float result and its inexact flag.
  typedef struct packed {
    logic [31:0] d;
    logic        p_lost;
  } s3_t;

endpackage

// File: rtl/int_to_float_pipe_lzc.sv
// Purpose: 32-bit leading-zero counter with all-zero flag.
// Latency: combinational.
// Backpressure: none (pure logic).
module lzc32 (
  input  logic [31:0] x,
  output logic [4:0]  cnt,
  output logic        all_zero
);

  // Scan upward so the highest set bit makes the last, winning assignment.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) cnt = 5'(31 - i);
    end
    all_zero = (x == 32'd0);
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Purpose: int32 (two's complement) to IEEE-754 single, round-to-nearest-even, with inexact flag.
// Latency: 3 cycles from accept to out_valid; throughput 1 per cycle.
// Backpressure: global stall - every stage holds while out_valid & ~out_ready; in_ready follows.
module int_to_float_pipe
  import int_to_float_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        p_lost
);

  logic advance;

  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s3_vld_q, s3_vld_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;

  logic [4:0]        lz;
  logic              lz_zero;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] frac_r;
  logic              frac_carry;
  logic              guard_bit;
  logic              sticky_bit;
  logic              round_up;
  logic [EXP_W-1:0]  e_r;

  // The pipe moves as a whole whenever the output slot is empty or being drained.
  assign advance   = ~s3_vld_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = s3_vld_q;
  assign d         = s3_q.d;
  assign p_lost    = s3_q.p_lost;

  // S1: split sign and take the magnitude; 0x80000000 keeps mag 0x80000000 as unsigned.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (advance) begin
      s1_vld_d  = in_valid;
      s1_d.sign = a[31];
      s1_d.mag  = a[31] ? (~a + 32'd1) : a;
      s1_d.zero = (a == 32'd0);
    end
  end

  lzc32 u_lzc (
    .x        (s1_q.mag),
    .cnt      (lz),
    .all_zero (lz_zero)
  );

  // S2: normalize so the leading one lands in bit 31, then drop it; exponent from the shift.
  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (advance) begin
      s2_vld_d  = s1_vld_q;
      s2_d.sign = s1_q.sign;
      // Both flags mark the same condition; either one forces the zero encoding.
      s2_d.zero = s1_q.zero | lz_zero;
      s2_d.m    = 31'(s1_q.mag << lz);
      s2_d.e    = EXP_W'(INT_TO_FP_EXP_BASE) - {3'b000, lz};
    end
  end

  // S3 rounding terms: keep 23 fraction bits, guard below them, sticky OR of the rest.
  always_comb begin
    frac                 = s2_q.m[30:8];
    guard_bit            = s2_q.m[7];
    sticky_bit           = |s2_q.m[6:0];
    round_up             = guard_bit & (sticky_bit | frac[0]);
    {frac_carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
    // A fraction overflow means the value rounded to the next power of two.
    e_r                  = s2_q.e + {{(EXP_W-1){1'b0}}, frac_carry};
  end

  // S3: pack sign/exponent/fraction; zero bypasses rounding and is always +0, exact.
  always_comb begin
    s3_vld_d = s3_vld_q;
    s3_d     = s3_q;
    if (advance) begin
      s3_vld_d = s2_vld_q;
      if (s2_q.zero) begin
        s3_d.d      = FP32_ZERO;
        s3_d.p_lost = 1'b0;
      end else begin
        s3_d.d      = {s2_q.sign, e_r, frac_r};
        s3_d.p_lost = guard_bit | sticky_bit;
      end
    end
  end

  // Stage registers; reset drops every in-flight result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
`timescale 1ns/1ps
module tb_int_to_float_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        p_lost;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] acc_a[$];
  int          acc_cyc[$];
  logic [31:0] obs_d[$];
  logic        obs_p[$];
  int          obs_cyc[$];

  logic        smp_ov, smp_ir, smp_p;
  logic [31:0] smp_d;

  int_to_float_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .p_lost    (p_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact magnitude, rounding by remainder against half an ulp.
  function automatic logic [32:0] ref_cvt(input logic [31:0] x);
    longint v, mag, q, rem, half;
    int k, sh;
    logic p;
    logic [7:0] ex;
    logic [22:0] fr;
    v   = longint'($signed(x));
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 33'd0;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag >= (longint'(1) << i)) k = i;
    p = 1'b0;
    if (k <= 23) begin
      q = mag << (23 - k);
    end else begin
      sh   = k - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      p    = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        k = k + 1;
      end
    end
    ex = 8'(127 + k);
    fr = q[22:0];
    return {p, x[31], ex, fr};
  endfunction

  // One clock of stimulus; entered and left at posedge+1, samples at posedge+3.
  task automatic drive_cycle(input logic iv, input logic [31:0] av, input logic ordy,
                             output logic accepted);
    in_valid  = iv;
    a         = av;
    out_ready = ordy;
    #2;
    smp_ov   = out_valid;
    smp_ir   = in_ready;
    smp_d    = d;
    smp_p    = p_lost;
    accepted = iv && in_ready;
    if (accepted) begin
      acc_a.push_back(av);
      acc_cyc.push_back(cyc);
    end
    if (out_valid && ordy) begin
      obs_d.push_back(d);
      obs_p.push_back(p_lost);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_q();
    acc_a.delete(); acc_cyc.delete();
    obs_d.delete(); obs_p.delete(); obs_cyc.delete();
  endtask

  // Feed n operands back to back with out_ready high, then drain.
  task automatic run_stream(input logic [31:0] v[8], input int n);
    logic acc;
    clear_q();
    for (int i = 0; i < n; i++) drive_cycle(1'b1, v[i], 1'b1, acc);
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 32'd0, 1'b1, acc);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_d: got %h want 00000000", d); end
    n_cmp++; if (p_lost !== 1'b0) begin n_bad++; $display("FAIL reset_p_lost: got %b want 0", p_lost); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [31:0] v[8];
    logic [31:0] ed[3];
    logic        ep[3];
    v = '{32'd1, 32'hFFFF_FFFB, 32'd0, 0, 0, 0, 0, 0};
    ed = '{32'h3F80_0000, 32'hC0A0_0000, 32'h0000_0000};
    ep = '{1'b0, 1'b0, 1'b0};
    run_stream(v, 3);
    n_cmp++;
    if (obs_d.size() !== 3) begin
      n_bad++; $display("FAIL basic_count: got %0d want 3", obs_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (obs_d[i] !== ed[i]) begin n_bad++; $display("FAIL basic_d[%0d]: got %h want %h", i, obs_d[i], ed[i]); end
        n_cmp++; if (obs_p[i] !== ep[i]) begin n_bad++; $display("FAIL basic_p[%0d]: got %b want %b", i, obs_p[i], ep[i]); end
        n_cmp++;
        if (obs_cyc[i] - acc_cyc[i] !== 3) begin
          n_bad++; $display("FAIL basic_latency[%0d]: got %0d want 3", i, obs_cyc[i] - acc_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] v[8];
    logic [31:0] ed[4];
    logic        ep[4];
    v  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0, 0};
    ed = '{32'hCF00_0000, 32'h4F00_0000, 32'hBF80_0000, 32'h4000_0000};
    ep = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_stream(v, 4);
    n_cmp++;
    if (obs_d.size() !== 4) begin
      n_bad++; $display("FAIL extremes_count: got %0d want 4", obs_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (obs_d[i] !== ed[i]) begin n_bad++; $display("FAIL extremes_d[%0d]: got %h want %h", i, obs_d[i], ed[i]); end
        n_cmp++; if (obs_p[i] !== ep[i]) begin n_bad++; $display("FAIL extremes_p[%0d]: got %b want %b", i, obs_p[i], ep[i]); end
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] v[8];
    logic [31:0] ed[7];
    logic        ep[7];
    v  = '{32'h0100_0001, 32'h0100_0003, 32'h00FF_FFFF, 32'h0100_0002,
           32'h0100_0005, 32'h0100_0007, 32'hFEFF_FFFD, 0};
    ed = '{32'h4B80_0000, 32'h4B80_0002, 32'h4B7F_FFFF, 32'h4B80_0001,
           32'h4B80_0002, 32'h4B80_0004, 32'hCB80_0002};
    ep = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_stream(v, 7);
    n_cmp++;
    if (obs_d.size() !== 7) begin
      n_bad++; $display("FAIL rne_count: got %0d want 7", obs_d.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++; if (obs_d[i] !== ed[i]) begin n_bad++; $display("FAIL rne_d[%0d]: got %h want %h", i, obs_d[i], ed[i]); end
        n_cmp++; if (obs_p[i] !== ep[i]) begin n_bad++; $display("FAIL rne_p[%0d]: got %b want %b", i, obs_p[i], ep[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    logic ordy;
    logic [31:0] held;
    logic [31:0] ed[8];
    int idx;
    ed = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
           32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    clear_q();
    idx  = 0;
    held = 32'd0;
    for (int k = 0; k < 40 && obs_d.size() < 8; k++) begin
      ordy = !(k >= 4 && k <= 7);
      drive_cycle(idx < 8, 32'(idx + 1), ordy, acc);
      if (acc) idx++;
      if (k == 4) held = smp_d;
      if (k >= 4 && k <= 7) begin
        n_cmp++; if (smp_ir !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready@%0d: got %b want 0", k, smp_ir); end
        n_cmp++; if (smp_ov !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid@%0d: got %b want 1", k, smp_ov); end
      end
      if (k >= 5 && k <= 7) begin
        n_cmp++; if (smp_d !== held) begin n_bad++; $display("FAIL bp_d_stable@%0d: got %h want %h", k, smp_d, held); end
      end
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'd0, 1'b1, acc);
    n_cmp++;
    if (obs_d.size() !== 8) begin
      n_bad++; $display("FAIL bp_count: got %0d want 8", obs_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (obs_d[i] !== ed[i]) begin n_bad++; $display("FAIL bp_d[%0d]: got %h want %h", i, obs_d[i], ed[i]); end
      end
    end
  endtask

  task automatic test_bubbles();
    logic acc;
    logic iv[8];
    logic eov[8];
    iv  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    eov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    clear_q();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(iv[k], 32'd100 + 32'(k), 1'b1, acc);
      n_cmp++;
      if (smp_ov !== eov[k]) begin n_bad++; $display("FAIL bubble_ov@%0d: got %b want %b", k, smp_ov, eov[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic acc;
    logic seen;
    clear_q();
    drive_cycle(1'b1, 32'd10, 1'b1, acc);
    drive_cycle(1'b1, 32'd20, 1'b1, acc);
    drive_cycle(1'b0, 32'd0, 1'b0, acc);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", out_valid); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_async_drop: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_d.delete();
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b0, 32'd0, 1'b1, acc);
      if (smp_ov) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got %b want 0", seen); end
    n_cmp++; if (smp_ir !== 1'b1) begin n_bad++; $display("FAIL midrst_ready_after: got %b want 1", smp_ir); end
  endtask

  task automatic test_random();
    logic acc;
    logic iv, ordy;
    logic [31:0] av;
    logic [32:0] exp_v;
    int n_sent;
    clear_q();
    n_sent = 0;
    for (int k = 0; k < 40000 && obs_d.size() < 10000; k++) begin
      iv   = (n_sent < 10000) && ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: av = $urandom;
        1: av = 32'($urandom_range(0, 32'h0200_0000));
        2: av = -32'($urandom_range(0, 32'h0200_0000));
        default: av = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
      endcase
      drive_cycle(iv, av, ordy, acc);
      if (acc) n_sent++;
    end
    n_cmp++;
    if (obs_d.size() !== 10000 || acc_a.size() !== 10000) begin
      n_bad++; $display("FAIL rand_count: got %0d/%0d want 10000", obs_d.size(), acc_a.size());
    end else begin
      for (int i = 0; i < 10000; i++) begin
        exp_v = ref_cvt(acc_a[i]);
        n_cmp++;
        if ({obs_p[i], obs_d[i]} !== exp_v) begin
          n_bad++;
          $display("FAIL rand[%0d] a=%h: got d=%h p=%b want d=%h p=%b",
                   i, acc_a[i], obs_d[i], obs_p[i], exp_v[31:0], exp_v[32]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_rounding();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
